labfinalsoc_key_debounce: RTL and testbench

Per-key synchronizer and debouncer for the board pushbuttons, placed directly upstream of the key PIO input port. It converts raw, asynchronous, active-low `KEY` pins into clean, active-high levels. Its `key_level` output drives the PIO `in_port` unchanged. It also produces single-cycle press and release strobes for game-logic consumers, with optional hold-to-repeat for held keys.

---
 rtl/labfinalsoc_key_debounce.sv | 146 ++++++++++++++
 tb/tb_labfinalsoc_key_debounce.sv | 136 +++++++++++++
 2 files changed

// File: rtl/labfinalsoc_key_debounce.sv
// Pushbutton synchronizer/debouncer feeding the key PIO, with press/release strobes.
// Build option: define LABFINALSOC_KEY_REPEAT_EN to add hold-to-repeat press strobes.
module labfinalsoc_key_debounce #(
    parameter int WIDTH           = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] key_n,
    output logic [WIDTH-1:0] key_level,
    output logic [WIDTH-1:0] key_press,
    output logic [WIDTH-1:0] key_release
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

`ifdef LABFINALSOC_KEY_REPEAT_EN
    localparam int RMAXV = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW = $clog2(RMAXV);
    localparam logic [RW-1:0] RD_END = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RP_END = RW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        R_IDLE,
        R_DELAY,
        R_REPEAT
    } rep_state_t;
`endif

    // Counters and the repeat timer need at least two cycles to be meaningful.
    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_bad_cfg
        $error("labfinalsoc_key_debounce: cycle parameters must be >= 2");
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_key
        logic [1:0]    sync_q;
        logic [CW-1:0] cnt;
        logic          lvl_q;
        logic          press_q;
        logic          rel_q;
        logic          sync;
        logic          diff;
        logic          done;
        logic          rise;
        logic          fall;
        logic          rep_fire;

        assign sync = sync_q[1];
        assign diff = sync != lvl_q;
        assign done = diff && (cnt == CMAX);
        assign rise = done && sync;
        assign fall = done && !sync;

        assign key_level[i]   = lvl_q;
        assign key_press[i]   = press_q;
        assign key_release[i] = rel_q;

        // Synchronize the pin, count stable cycles, accept the new level and strobe it.
        always_ff @(posedge clk) begin
            if (reset) begin
                sync_q  <= '0;
                cnt     <= '0;
                lvl_q   <= 1'b0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
            end else begin
                sync_q <= {sync_q[0], ~key_n[i]};
                if (!diff) begin
                    cnt <= '0;
                end else if (cnt == CMAX) begin
                    cnt   <= '0;
                    lvl_q <= sync;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                press_q <= rise | rep_fire;
                rel_q   <= fall;
            end
        end

`ifdef LABFINALSOC_KEY_REPEAT_EN
        rep_state_t    st;
        rep_state_t    st_nx;
        logic [RW-1:0] rcnt;
        logic [RW-1:0] rcnt_nx;

        // Repeat state and timer registers.
        always_ff @(posedge clk) begin
            if (reset) begin
                st   <= R_IDLE;
                rcnt <= '0;
            end else begin
                st   <= st_nx;
                rcnt <= rcnt_nx;
            end
        end

        // Release wins over everything so no repeat lands on or after the release strobe.
        always_comb begin
            st_nx    = st;
            rcnt_nx  = rcnt;
            rep_fire = 1'b0;
            if (fall) begin
                st_nx   = R_IDLE;
                rcnt_nx = '0;
            end else if (rise) begin
                st_nx   = R_DELAY;
                rcnt_nx = '0;
            end else begin
                unique case (st)
                    R_IDLE: begin
                        rcnt_nx = '0;
                    end
                    R_DELAY: begin
                        if (rcnt == RD_END) begin
                            rep_fire = 1'b1;
                            rcnt_nx  = '0;
                            st_nx    = R_REPEAT;
                        end else begin
                            rcnt_nx = rcnt + 1'b1;
                        end
                    end
                    R_REPEAT: begin
                        if (rcnt == RP_END) begin
                            rep_fire = 1'b1;
                            rcnt_nx  = '0;
                        end else begin
                            rcnt_nx = rcnt + 1'b1;
                        end
                    end
                    default: begin
                        st_nx   = R_IDLE;
                        rcnt_nx = '0;
                    end
                endcase
            end
        end
`else
        assign rep_fire = 1'b0;
`endif
    end

endmodule

// File: tb/tb_labfinalsoc_key_debounce.sv
// Directed bench for labfinalsoc_key_debounce (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3).
// Expectations follow LABFINALSOC_KEY_REPEAT_EN when it is defined.
module tb_labfinalsoc_key_debounce;

`ifdef LABFINALSOC_KEY_REPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] key_n;
    logic [1:0] key_level;
    logic [1:0] key_press;
    logic [1:0] key_release;

    int n_chk = 0;
    int n_err = 0;

    labfinalsoc_key_debounce #(
        .WIDTH(2),
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY(10),
        .REPEAT_PERIOD(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .key_n(key_n),
        .key_level(key_level),
        .key_press(key_press),
        .key_release(key_release)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [1:0] got, input logic [1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock, then compare all three outputs just after the edge.
    task automatic step(input string tag, input logic [1:0] l, input logic [1:0] p,
                        input logic [1:0] r);
        @(posedge clk);
        #1;
        chk({tag, ".level"}, key_level, l);
        chk({tag, ".press"}, key_press, p);
        chk({tag, ".release"}, key_release, r);
    endtask

    // k = cycles since the press strobe cycle P.
    function automatic bit rep_hit(input int k);
        if (k == 0) return 1'b1;
        if (REP && k >= 10 && ((k - 10) % 3) == 0) return 1'b1;
        return 1'b0;
    endfunction

    // Press key b, hold for 'hold' cycles after P, release and watch for stray strobes.
    task automatic press_cycle(input string tag, input int b, input int hold);
        logic [1:0] m;
        m = 2'b00;
        m[b] = 1'b1;
        key_n = key_n & ~m;
        for (int i = 0; i < 5; i++) step({tag, ".deb"}, 2'b00, 2'b00, 2'b00);
        step({tag, ".rise"}, m, m, 2'b00);
        for (int k = 1; k < hold; k++)
            step({tag, ".hold"}, m, rep_hit(k) ? m : 2'b00, 2'b00);
        key_n = key_n | m;
        for (int i = 0; i < 5; i++)
            step({tag, ".rdeb"}, m, rep_hit(hold + i) ? m : 2'b00, 2'b00);
        step({tag, ".fall"}, 2'b00, 2'b00, m);
        for (int i = 0; i < 15; i++) step({tag, ".quiet"}, 2'b00, 2'b00, 2'b00);
    endtask

    initial begin
        reset = 1'b1;
        key_n = 2'b00;
        #1;
        for (int i = 0; i < 3; i++) step("rst", 2'b00, 2'b00, 2'b00);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) step("post_rst", 2'b00, 2'b00, 2'b00);
        step("post_rst.rise", 2'b11, 2'b11, 2'b00);
        step("post_rst.held", 2'b11, 2'b00, 2'b00);
        key_n = 2'b11;
        for (int i = 0; i < 5; i++) step("both_rel", 2'b11, 2'b00, 2'b00);
        step("both_rel.fall", 2'b00, 2'b00, 2'b11);
        step("both_rel.idle", 2'b00, 2'b00, 2'b00);

        press_cycle("clean", 0, 20);

        key_n = 2'b10; step("bounce", 2'b00, 2'b00, 2'b00);
        step("bounce", 2'b00, 2'b00, 2'b00);
        step("bounce", 2'b00, 2'b00, 2'b00);
        key_n = 2'b11; step("bounce", 2'b00, 2'b00, 2'b00);
        key_n = 2'b10; step("bounce", 2'b00, 2'b00, 2'b00);
        step("bounce", 2'b00, 2'b00, 2'b00);
        key_n = 2'b11;
        for (int i = 0; i < 10; i++) step("bounce.tail", 2'b00, 2'b00, 2'b00);

        key_n = 2'b10;
        step("indep", 2'b00, 2'b00, 2'b00);
        step("indep", 2'b00, 2'b00, 2'b00);
        key_n = 2'b00;
        for (int i = 0; i < 3; i++) step("indep", 2'b00, 2'b00, 2'b00);
        step("indep.b0", 2'b01, 2'b01, 2'b00);
        step("indep.wait", 2'b01, 2'b00, 2'b00);
        step("indep.b1", 2'b11, 2'b10, 2'b00);
        step("indep.held", 2'b11, 2'b00, 2'b00);
        key_n = 2'b11;
        for (int i = 0; i < 5; i++) step("indep.rel", 2'b11, 2'b00, 2'b00);
        step("indep.fall", 2'b00, 2'b00, 2'b11);
        step("indep.idle", 2'b00, 2'b00, 2'b00);

        key_n = 2'b01;
        for (int i = 0; i < 4; i++) step("midrst", 2'b00, 2'b00, 2'b00);
        reset = 1'b1;
        step("midrst.rst", 2'b00, 2'b00, 2'b00);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) step("midrst.deb", 2'b00, 2'b00, 2'b00);
        step("midrst.rise", 2'b10, 2'b10, 2'b00);
        key_n = 2'b11;
        for (int i = 0; i < 5; i++) step("midrst.rel", 2'b10, 2'b00, 2'b00);
        step("midrst.fall", 2'b00, 2'b00, 2'b10);
        step("midrst.idle", 2'b00, 2'b00, 2'b00);

        press_cycle("repeat", 0, 30);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
